// File: rtl/custom_axi_ip_regs.sv
// custom_axi_ip_regs: AXI4-Lite registers (operand, START, status, result) for custom_axi_ip; ports: clk_i/rst_ni, s_axi_* slave, ipreg_data_o/enable_o to core, ipreg_data_i/wen_i/status_i from core
module custom_axi_ip_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [2*DATA_WIDTH-1:0]   ipreg_data_o,
  output logic                      enable_o,
  input  logic [2*DATA_WIDTH-1:0]   ipreg_data_i,
  input  logic                      wen_i,
  input  logic [1:0]                status_i
);
  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rstate_e;
  wstate_e wstate, wnext;
  rstate_e rstate, rnext;
  logic [DATA_WIDTH-1:0] data_lo, data_hi, result_lo, result_hi, rmux;
  logic result_valid, start_dropped, start_req, wack, rack;
  logic [2:0] waddr, raddr;
  logic unused;
  assign unused = ^{s_axi_awaddr[1:0], s_axi_awaddr[ADDR_WIDTH-1:5], s_axi_araddr[1:0], s_axi_araddr[ADDR_WIDTH-1:5]};
  assign waddr = s_axi_awaddr[4:2];
  assign raddr = s_axi_araddr[4:2];
  assign wack = wstate == W_ACK;
  assign rack = rstate == R_ACK;
  assign start_req = wack && waddr == 3'd0 && s_axi_wdata[0] && s_axi_wstrb[0];
  assign ipreg_data_o = {data_hi, data_lo};
  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old, input logic [DATA_WIDTH-1:0] d, input logic [DATA_WIDTH/8-1:0] s);
    merge = old;
    for (int i = 0; i < DATA_WIDTH/8; i++) if (s[i]) merge[i*8 +: 8] = d[i*8 +: 8];
  endfunction
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
    end else begin
      wstate <= wnext;
      rstate <= rnext;
    end
  always_comb begin
    wnext = wstate;
    s_axi_awready = 1'b0;
    s_axi_wready = 1'b0;
    s_axi_bvalid = 1'b0;
    case (wstate)
      W_IDLE: wnext = s_axi_awvalid && s_axi_wvalid ? W_ACK : W_IDLE;
      W_ACK: begin
        s_axi_awready = 1'b1;
        s_axi_wready = 1'b1;
        wnext = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        wnext = s_axi_bready ? W_IDLE : W_RESP;
      end
      default: wnext = W_IDLE;
    endcase
  end
  always_comb begin
    rnext = rstate;
    s_axi_arready = 1'b0;
    s_axi_rvalid = 1'b0;
    case (rstate)
      R_IDLE: rnext = s_axi_arvalid ? R_ACK : R_IDLE;
      R_ACK: begin
        s_axi_arready = 1'b1;
        rnext = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        rnext = s_axi_rready ? R_IDLE : R_DATA;
      end
      default: rnext = R_IDLE;
    endcase
  end
  always_comb
    rmux = raddr == 3'd1 ? {{(DATA_WIDTH-4){1'b0}}, start_dropped, result_valid, status_i} :
           raddr == 3'd2 ? data_lo :
           raddr == 3'd3 ? data_hi :
           raddr == 3'd4 ? result_lo :
           raddr == 3'd5 ? result_hi : '0;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      data_lo <= '0;
      data_hi <= '0;
      result_lo <= '0;
      result_hi <= '0;
      result_valid <= 1'b0;
      start_dropped <= 1'b0;
      enable_o <= 1'b0;
      s_axi_bresp <= 2'b00;
      s_axi_rresp <= 2'b00;
      s_axi_rdata <= '0;
    end else begin
      enable_o <= start_req && status_i == 2'd0;
      if (wack && waddr == 3'd2) data_lo <= merge(data_lo, s_axi_wdata, s_axi_wstrb);
      if (wack && waddr == 3'd3) data_hi <= merge(data_hi, s_axi_wdata, s_axi_wstrb);
      if (start_req && status_i != 2'd0) start_dropped <= 1'b1;
      else if (wack && waddr == 3'd1 && s_axi_wdata[3] && s_axi_wstrb[0]) start_dropped <= 1'b0;
      if (wen_i) {result_hi, result_lo} <= ipreg_data_i;
      // a capture in the same cycle as the RESULT_HI read must leave the flag set
      if (wen_i) result_valid <= 1'b1;
      else if (rack && raddr == 3'd5) result_valid <= 1'b0;
      if (wack) s_axi_bresp <= waddr > 3'd5 ? 2'b10 : 2'b00;
      if (rack) begin
        s_axi_rdata <= rmux;
        s_axi_rresp <= raddr > 3'd5 ? 2'b10 : 2'b00;
      end
    end
endmodule

// File: tb/tb_custom_axi_ip_regs.sv
// tb_custom_axi_ip_regs: directed table, corner sequences and randomized model checks for custom_axi_ip_regs
module tb_custom_axi_ip_regs;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic [7:0] awaddr = '0, araddr = '0;
  logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1, wen_i = 0;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic [1:0] status_i = '0;
  logic [63:0] ipreg_data_i = '0;
  logic awready, wready, bvalid, arready, rvalid, enable_o;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [63:0] ipreg_data_o;
  int checks = 0, errors = 0, en_cnt = 0;
  logic [31:0] m_lo = '0, m_hi = '0;
  logic [63:0] m_res = '0;
  bit m_rv = 0, m_sd = 0;

  custom_axi_ip_regs dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .ipreg_data_o(ipreg_data_o), .enable_o(enable_o),
    .ipreg_data_i(ipreg_data_i), .wen_i(wen_i), .status_i(status_i)
  );

  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) if (enable_o) en_cnt++;

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  status;
    logic [63:0] exp_val;
    logic [1:0]  exp_resp;
    bit          exp_en;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic en_b, output logic [63:0] ipd);
    int n = 0;
    @(posedge clk_i); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    do begin @(negedge clk_i); n++; end while (!awready && n < 20);
    chk("aw_latency", 64'(n), 64'd2);
    chk("wready", wready, 1'b1);
    @(posedge clk_i); #1;
    awvalid = 0; wvalid = 0;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!bvalid && n < 20);
    chk("b_latency", 64'(n), 64'd1);
    resp = bresp; en_b = enable_o; ipd = ipreg_data_o;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    @(posedge clk_i); #1;
    araddr = a; arvalid = 1;
    do begin @(negedge clk_i); n++; end while (!arready && n < 20);
    chk("ar_latency", 64'(n), 64'd2);
    @(posedge clk_i); #1;
    arvalid = 0;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!rvalid && n < 20);
    chk("r_latency", 64'(n), 64'd1);
    d = rdata; r = rresp;
  endtask

  task automatic pulse_wen(input logic [63:0] v);
    @(posedge clk_i); #1;
    wen_i = 1; ipreg_data_i = v;
    @(posedge clk_i); #1;
    wen_i = 0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] st, output logic [1:0] resp, output logic en);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    resp = a[4:2] > 3'd5 ? 2'b10 : 2'b00;
    en = 0;
    case (a[4:2])
      3'd0: if (d[0] && s[0]) begin if (st == 2'd0) en = 1; else m_sd = 1; end
      3'd1: if (d[3] && s[0]) m_sd = 0;
      3'd2: m_lo = (m_lo & ~mask) | (d & mask);
      3'd3: m_hi = (m_hi & ~mask) | (d & mask);
      default: ;
    endcase
  endtask

  task automatic model_read(input logic [7:0] a, input logic [1:0] st, output logic [31:0] v, output logic [1:0] resp);
    resp = a[4:2] > 3'd5 ? 2'b10 : 2'b00;
    case (a[4:2])
      3'd1: v = {28'd0, m_sd, m_rv, st};
      3'd2: v = m_lo;
      3'd3: v = m_hi;
      3'd4: v = m_res[31:0];
      3'd5: begin v = m_res[63:32]; m_rv = 0; end
      default: v = 32'd0;
    endcase
  endtask

  initial begin
    logic [1:0] resp, eresp;
    logic [31:0] rd, ev;
    logic [63:0] ipd;
    logic en_b, een;
    int e0;
    tbl[0]  = '{0, 8'h08, 32'h0,          4'h0, 2'd0, 64'h0,                   2'b00, 0};
    tbl[1]  = '{0, 8'h10, 32'h0,          4'h0, 2'd0, 64'h0,                   2'b00, 0};
    tbl[2]  = '{0, 8'h04, 32'h0,          4'h0, 2'd0, 64'h0,                   2'b00, 0};
    tbl[3]  = '{0, 8'h18, 32'h0,          4'h0, 2'd0, 64'h0,                   2'b10, 0};
    tbl[4]  = '{1, 8'h1C, 32'hFFFF_FFFF,  4'hF, 2'd0, 64'h0,                   2'b10, 0};
    tbl[5]  = '{0, 8'h08, 32'h0,          4'h0, 2'd0, 64'h0,                   2'b00, 0};
    tbl[6]  = '{1, 8'h08, 32'h5,          4'hF, 2'd0, 64'h0000_0000_0000_0005, 2'b00, 0};
    tbl[7]  = '{1, 8'h0C, 32'h7,          4'hF, 2'd0, 64'h0000_0007_0000_0005, 2'b00, 0};
    tbl[8]  = '{1, 8'h00, 32'h1,          4'hF, 2'd0, 64'h0000_0007_0000_0005, 2'b00, 1};
    tbl[9]  = '{1, 8'h00, 32'h1,          4'hF, 2'd1, 64'h0000_0007_0000_0005, 2'b00, 0};
    tbl[10] = '{0, 8'h04, 32'h0,          4'h0, 2'd1, 64'h9,                   2'b00, 0};
    tbl[11] = '{1, 8'h04, 32'h8,          4'hF, 2'd1, 64'h0000_0007_0000_0005, 2'b00, 0};
    tbl[12] = '{0, 8'h04, 32'h0,          4'h0, 2'd1, 64'h1,                   2'b00, 0};
    tbl[13] = '{1, 8'h08, 32'hFFFF_FFFF,  4'hF, 2'd0, 64'h0000_0007_FFFF_FFFF, 2'b00, 0};
    tbl[14] = '{1, 8'h08, 32'h0,          4'h2, 2'd0, 64'h0000_0007_FFFF_00FF, 2'b00, 0};
    tbl[15] = '{0, 8'h08, 32'h0,          4'h0, 2'd0, 64'hFFFF_00FF,           2'b00, 0};
    tbl[16] = '{1, 8'h10, 32'h1234,       4'hF, 2'd0, 64'h0000_0007_FFFF_00FF, 2'b00, 0};
    tbl[17] = '{0, 8'h10, 32'h0,          4'h0, 2'd0, 64'h0,                   2'b00, 0};
    tbl[18] = '{0, 8'h0C, 32'h0,          4'h0, 2'd0, 64'h7,                   2'b00, 0};
    tbl[19] = '{0, 8'h00, 32'h0,          4'h0, 2'd0, 64'h0,                   2'b00, 0};

    repeat (3) @(negedge clk_i);
    chk("rst_awready", awready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_resp", {bresp, rresp}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_enable", enable_o, 0);
    chk("rst_ipreg", ipreg_data_o, 0);
    rst_ni = 1;

    for (int i = 0; i < 20; i++) begin
      status_i = tbl[i].status;
      if (tbl[i].is_wr) begin
        e0 = en_cnt;
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, resp, en_b, ipd);
        repeat (2) @(negedge clk_i);
        chk($sformatf("t%0d_bresp", i), resp, tbl[i].exp_resp);
        chk($sformatf("t%0d_en_at_bvalid", i), en_b, tbl[i].exp_en);
        chk($sformatf("t%0d_pulses", i), 64'(en_cnt - e0), 64'(tbl[i].exp_en));
        chk($sformatf("t%0d_ipreg", i), ipd, tbl[i].exp_val);
      end else begin
        axi_read(tbl[i].addr, rd, resp);
        chk($sformatf("t%0d_rdata", i), rd, tbl[i].exp_val);
        chk($sformatf("t%0d_rresp", i), resp, tbl[i].exp_resp);
      end
    end

    status_i = 2'd0;
    pulse_wen(64'h0000_0008_0000_0006);
    axi_read(8'h04, rd, resp); chk("res_status_set", rd, 32'h4);
    axi_read(8'h10, rd, resp); chk("res_lo", rd, 32'h6);
    axi_read(8'h14, rd, resp); chk("res_hi", rd, 32'h8);
    axi_read(8'h04, rd, resp); chk("res_status_clr", rd, 32'h0);
    pulse_wen(64'h0000_0008_0000_0006);
    @(posedge clk_i); #1;
    araddr = 8'h14; arvalid = 1;
    @(posedge clk_i); #1;
    wen_i = 1; ipreg_data_i = 64'h0000_000A_0000_0009;
    @(negedge clk_i); chk("coinc_arready", arready, 1);
    @(posedge clk_i); #1;
    wen_i = 0; arvalid = 0;
    @(negedge clk_i);
    chk("coinc_rvalid", rvalid, 1);
    chk("coinc_old_hi", rdata, 32'h8);
    axi_read(8'h04, rd, resp); chk("coinc_status_kept", rd, 32'h4);
    axi_read(8'h10, rd, resp); chk("coinc_new_lo", rd, 32'h9);

    m_lo = 32'hFFFF_00FF; m_hi = 32'h7; m_res = 64'h0000_000A_0000_0009; m_rv = 1; m_sd = 0;
    for (int i = 0; i < 80; i++) begin
      logic [7:0] a;
      logic [31:0] d;
      logic [3:0] s;
      a = 8'($urandom_range(0, 7) * 4);
      d = $urandom;
      s = 4'($urandom);
      status_i = $urandom_range(0, 1) ? 2'd0 : 2'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) begin
        ipd = {$urandom, $urandom};
        pulse_wen(ipd);
        m_res = ipd; m_rv = 1;
      end
      if ($urandom_range(0, 1)) begin
        model_write(a, d, s, status_i, eresp, een);
        e0 = en_cnt;
        axi_write(a, d, s, resp, en_b, ipd);
        repeat (2) @(negedge clk_i);
        chk($sformatf("r%0d_bresp", i), resp, eresp);
        chk($sformatf("r%0d_en", i), en_b, een);
        chk($sformatf("r%0d_pulses", i), 64'(en_cnt - e0), 64'(een));
        chk($sformatf("r%0d_ipreg", i), ipd, {m_hi, m_lo});
      end else begin
        model_read(a, status_i, ev, eresp);
        axi_read(a, rd, resp);
        chk($sformatf("r%0d_rdata", i), rd, ev);
        chk($sformatf("r%0d_rresp", i), resp, eresp);
      end
    end

    status_i = 2'd0;
    bready = 0; rready = 0;
    m_lo = 32'h0000_A5A5;
    @(posedge clk_i); #1;
    awaddr = 8'h08; wdata = 32'h0000_A5A5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 8'h0C; arvalid = 1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    arvalid = 0;
    awaddr = 8'h0C; wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("hold_bvalid", bvalid, 1);
      chk("hold_rvalid", rvalid, 1);
      chk("hold_bresp", bresp, 0);
      chk("hold_rdata", rdata, m_hi);
      chk("hold_no_accept", {awready, wready}, 0);
      chk("hold_ipreg", ipreg_data_o, {m_hi, m_lo});
    end
    #2 rst_ni = 0;
    #1;
    chk("arst_bvalid", bvalid, 0);
    chk("arst_rvalid", rvalid, 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_ipreg", ipreg_data_o, 0);
    awvalid = 0; wvalid = 0; bready = 1; rready = 1;
    @(negedge clk_i); rst_ni = 1;
    axi_read(8'h08, rd, resp); chk("post_rst_lo", rd, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/custom_axi_ip_regs.md
# custom_axi_ip_regs

AXI4-Lite slave register block that sits directly upstream of the `custom_axi_ip` compute core. It gives software a 64-bit operand register, a START control that pulses the core's enable, live readback of the core's status, and a result register captured on the core's write-enable. One write FSM and one read FSM operate independently. Each serves one outstanding transaction.

## Interface
- `DATA_WIDTH`, 32: AXI data width. Only 32 is supported.
- `ADDR_WIDTH`, 8: AXI address width. Decode uses `addr[4:2]`; `addr[1:0]` is ignored.
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `s_axi_awaddr` in ADDR_WIDTH, `s_axi_awvalid` in 1, `s_axi_awready` out 1: write address channel.
- `s_axi_wdata` in 32, `s_axi_wstrb` in 4, `s_axi_wvalid` in 1, `s_axi_wready` out 1: write data channel.
- `s_axi_bresp` out 2, `s_axi_bvalid` out 1, `s_axi_bready` in 1: write response channel.
- `s_axi_araddr` in ADDR_WIDTH, `s_axi_arvalid` in 1, `s_axi_arready` out 1: read address channel.
- `s_axi_rdata` out 32, `s_axi_rresp` out 2, `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data channel.
- `ipreg_data_o` out 64: operand to the core, `{DATA_HI, DATA_LO}`.
- `enable_o` out 1: single-cycle start pulse to the core.
- `ipreg_data_i` in 64: result from the core.
- `wen_i` in 1: result-valid strobe from the core.
- `status_i` in 2: core state, `custom_axi_ip_pkg::status_e` (IDLE=0, BUSY=1, DONE=2, ERROR=3).

## Operation
Register map (byte offsets):
- 0x00 CTRL, W1S.
  - bit0 START. Writing 1 with `wstrb[0]` set requests a start. Reads as 0.
- 0x04 STATUS, RO except bit3.
  - [1:0] `status_i`, live.
  - bit2 RESULT_VALID.
  - bit3 START_DROPPED. Write 1 to clear.
- 0x08 DATA_LO, RW, reset 0.
- 0x0C DATA_HI, RW, reset 0. Byte strobes are honoured on DATA_LO and DATA_HI.
- 0x10 RESULT_LO, RO.
- 0x14 RESULT_HI, RO.
- Any other offset: write is discarded with bresp=SLVERR (2'b10); read returns rdata=0 with rresp=SLVERR.
- Writes to RO offsets 0x10 and 0x14 return OKAY and have no effect.

START handling:
- If `status_i`==IDLE in the write cycle, `enable_o` is high for exactly one cycle.
- Otherwise the request is dropped and START_DROPPED is set (sticky).

Result capture:
- `wen_i`=1 loads RESULT ← `ipreg_data_i` and sets RESULT_VALID.
- A read of RESULT_HI clears RESULT_VALID. If `wen_i` is high in the same cycle, set wins.

Write FSM states:
- W_IDLE → W_ACK when `awvalid && wvalid`.
- W_ACK: `awready`=`wready`=1 for one cycle; the register update happens this cycle; → W_RESP.
- W_RESP: `bvalid`=1, with bresp held stable, until `bready` → W_IDLE.
- Only AW valid or only W valid: wait in W_IDLE.

Read FSM states:
- R_IDLE → R_ACK when `arvalid`.
- R_ACK: `arready`=1 for one cycle; rdata and rresp are sampled; → R_DATA.
- R_DATA: `rvalid`=1, with rdata held stable, until `rready` → R_IDLE.

## Timing
- Reset values:
  - all ready/valid outputs 0, bresp=rresp=0, rdata=0.
  - `ipreg_data_o`=0, `enable_o`=0.
  - RESULT=0, RESULT_VALID=0, START_DROPPED=0.
  - Both FSMs in IDLE.
- AW+W valid in cycle N:
  - `awready`/`wready` high in N+1, and the register takes its new value at the end of N+1.
  - `bvalid` high from N+2.
  - `enable_o` high in N+2 only, which is also the first cycle `ipreg_data_o` shows the new DATA values.
- AR valid in cycle N: `arready` high in N+1, `rvalid` and data from N+2.
- Read and write proceed concurrently. Same-register read and write in the same sample cycle: the read returns the pre-write value.
- `wen_i` in the read sample cycle: the read returns the old RESULT.
- Back-pressure: `bvalid`/`rvalid` hold indefinitely and no new transaction is accepted meanwhile.
- Reset asserted mid-transaction: all outputs go to reset values immediately (asynchronously) and the transaction is abandoned.
- `enable_o` never lasts longer than one cycle; back-to-back START writes yield separate pulses at least 3 cycles apart.

## Test plan
- Reset, then read every offset:
  - 0x08 and 0x10 return 0 with OKAY; STATUS returns 0x0.
  - 0x18 returns 0 with SLVERR.
  - Write 0x1C: bresp SLVERR and no register changes.
- Write DATA_LO=0x0000_0005 and DATA_HI=0x0000_0007, then CTRL=1 with `status_i`=IDLE:
  - `ipreg_data_o`=0x0000_0007_0000_0005.
  - `enable_o` is a single pulse in the cycle `bvalid` rises.
- Hold `status_i`=BUSY and write CTRL=1:
  - no `enable_o`; STATUS reads 0x9 (bit3 + BUSY).
  - Write STATUS=0x8, then STATUS reads 0x1.
- Pulse `wen_i` with `ipreg_data_i`=0x0000_0008_0000_0006:
  - STATUS bit2=1; RESULT_LO=0x6, RESULT_HI=0x8.
  - After the RESULT_HI read, bit2=0.
  - Repeat with `wen_i` coincident with the RESULT_HI read sample cycle: bit2 stays 1.
- DATA_LO=0xFFFF_FFFF, then write 0x0000_0000 with wstrb=4'b0010: DATA_LO=0xFFFF_00FF.
- Hold `bready`=0 and `rready`=0 for 10 cycles:
  - `bvalid`/`rvalid` and data stay stable; a second AW/W is not accepted.
  - Assert `rst_ni`=0 mid-hold: all valids drop the same cycle.
